// File: rtl/axi2per_pkg.sv
// Shared definitions for the AXI-to-peripheral bridge front end.
//   seq_state_e      request sequencer FSM states
//   dir_e            burst direction, also the arbiter's last_served encoding
//   AXI2PER_4K_MASK  low address bits that advance within a 4 KiB page
//   trans_info_t     per-beat info handed to the response stage
//   incr_4k          beat-to-beat address step inside the 4 KiB page
package axi2per_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_WRITE = 2'd1,
    SEQ_READ  = 2'd2
  } seq_state_e;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } dir_e;

  localparam logic [11:0] AXI2PER_4K_MASK = 12'hFFF;

  // Widest ID the response-stage struct can carry; narrower IDs are zero-extended.
  localparam int unsigned AXI2PER_MAX_ID_W = 16;

  typedef struct packed {
    logic [AXI2PER_MAX_ID_W-1:0] id;
    logic                        we;
    logic                        last;
  } trans_info_t;

  // Next word address inside the page: upper bits are held by the caller,
  // the byte offset of an unaligned first beat is dropped from then on.
  function automatic logic [11:0] incr_4k(input logic [11:0] a);
    return (a + 12'd4) & AXI2PER_4K_MASK & ~12'd3;
  endfunction

endpackage

// File: rtl/axi2per_rr_arb2.sv
// Two-way write/read arbiter with a last_served flop.
//   clk_i, rst_ni        clock, async active-low reset
//   en_i                 arbitration allowed (sequencer idle)
//   req_w_i, req_r_i     write / read candidates
//   gnt_w_o, gnt_r_o     one-hot grant; a grant is also the AX handshake,
//                        since the requester is valid whenever it is granted
module axi2per_rr_arb2
  import axi2per_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_w_i,
  input  logic req_r_i,
  output logic gnt_w_o,
  output logic gnt_r_o
);

  dir_e last_q;

  // On a tie the direction not served last wins; reset favours read first.
  always_comb begin
    gnt_w_o = en_i & req_w_i & (~req_r_i | (last_q == DIR_READ));
    gnt_r_o = en_i & req_r_i & (~req_w_i | (last_q == DIR_WRITE));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      last_q <= DIR_WRITE;
    else if (gnt_w_o) last_q <= DIR_WRITE;
    else if (gnt_r_o) last_q <= DIR_READ;
  end

endmodule

// File: rtl/axi2per_req_sequencer.sv
// Request stage of the AXI-to-peripheral bridge. Accepts one AW or AR burst
// at a time and splits it into single-word peripheral requests.
//   clk_i, rst_ni                      clock, async active-low reset
//   aw_* / w_* / ar_*                  AXI4 write address, write data, read address
//   per_req_o/per_gnt_i                peripheral request handshake
//   per_add_o, per_we_n_o,
//   per_wdata_o, per_be_o              peripheral request payload
//   trans_valid_o/id/we/last           granted-beat info for the response stage
//   aw_sync_o, ar_sync_o               one pulse per accepted burst (busy unit)
module axi2per_req_sequencer
  import axi2per_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [ID_WIDTH-1:0]       aw_id_i,

  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [DATA_WIDTH-1:0]     w_data_i,
  input  logic [3:0]                w_strb_i,

  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [ID_WIDTH-1:0]       ar_id_i,

  output logic                      per_req_o,
  input  logic                      per_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0] per_add_o,
  output logic                      per_we_n_o,
  output logic [DATA_WIDTH-1:0]     per_wdata_o,
  output logic [3:0]                per_be_o,

  output logic                      trans_valid_o,
  output logic [ID_WIDTH-1:0]       trans_id_o,
  output logic                      trans_we_o,
  output logic                      trans_last_o,

  output logic                      aw_sync_o,
  output logic                      ar_sync_o
);

  seq_state_e                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                cnt_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic                      gnt_w, gnt_r;
  logic                      fire;
  trans_info_t               info;

  axi2per_rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (state_q == SEQ_IDLE),
    .req_w_i (aw_valid_i),
    .req_r_i (ar_valid_i),
    .gnt_w_o (gnt_w),
    .gnt_r_o (gnt_r)
  );

  always_comb begin
    state_d     = state_q;
    aw_ready_o  = 1'b0;
    ar_ready_o  = 1'b0;
    w_ready_o   = 1'b0;
    per_req_o   = 1'b0;
    per_we_n_o  = 1'b1;
    per_wdata_o = '0;
    per_be_o    = 4'h0;
    aw_sync_o   = 1'b0;
    ar_sync_o   = 1'b0;
    fire        = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        aw_ready_o = gnt_w;
        ar_ready_o = gnt_r;
        aw_sync_o  = gnt_w;
        ar_sync_o  = gnt_r;
        if (gnt_w)      state_d = SEQ_WRITE;
        else if (gnt_r) state_d = SEQ_READ;
      end
      SEQ_WRITE: begin
        // Request only follows W so a stalled W never issues a half-formed write.
        per_req_o   = w_valid_i;
        w_ready_o   = per_gnt_i & w_valid_i;
        per_we_n_o  = 1'b0;
        per_wdata_o = w_data_i;
        per_be_o    = w_strb_i;
        fire        = per_gnt_i & w_valid_i;
        if (fire && cnt_q == 8'd0) state_d = SEQ_IDLE;
      end
      SEQ_READ: begin
        per_req_o = 1'b1;
        per_be_o  = 4'hF;
        fire      = per_gnt_i;
        if (fire && cnt_q == 8'd0) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
      addr_q  <= '0;
      cnt_q   <= 8'd0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_w) begin
        addr_q <= aw_addr_i;
        cnt_q  <= aw_len_i;
        id_q   <= aw_id_i;
      end else if (gnt_r) begin
        addr_q <= ar_addr_i;
        cnt_q  <= ar_len_i;
        id_q   <= ar_id_i;
      end else if (fire) begin
        addr_q <= {addr_q[AXI_ADDR_WIDTH-1:12], incr_4k(addr_q[11:0])};
        cnt_q  <= cnt_q - 8'd1;
      end
    end
  end

  assign per_add_o = addr_q;

  // Beat info is zero outside a granted beat so idle/reset values are clean.
  always_comb begin
    info      = '0;
    info.id   = fire ? AXI2PER_MAX_ID_W'(id_q) : '0;
    info.we   = fire & (state_q == SEQ_WRITE);
    info.last = fire & (cnt_q == 8'd0);
  end

  assign trans_valid_o = fire;
  assign trans_id_o    = ID_WIDTH'(info.id);
  assign trans_we_o    = info.we;
  assign trans_last_o  = info.last;

endmodule

// File: tb/tb_axi2per_req_sequencer.sv
module tb_axi2per_req_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        aw_valid_i, aw_ready_o;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [5:0]  aw_id_i;
  logic        w_valid_i, w_ready_o;
  logic [31:0] w_data_i;
  logic [3:0]  w_strb_i;
  logic        ar_valid_i, ar_ready_o;
  logic [31:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [5:0]  ar_id_i;
  logic        per_req_o, per_gnt_i, per_we_n_o;
  logic [31:0] per_add_o, per_wdata_o;
  logic [3:0]  per_be_o;
  logic        trans_valid_o, trans_we_o, trans_last_o;
  logic [5:0]  trans_id_o;
  logic        aw_sync_o, ar_sync_o;

  axi2per_req_sequencer #(.AXI_ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_id_i(ar_id_i),
    .per_req_o(per_req_o), .per_gnt_i(per_gnt_i), .per_add_o(per_add_o),
    .per_we_n_o(per_we_n_o), .per_wdata_o(per_wdata_o), .per_be_o(per_be_o),
    .trans_valid_o(trans_valid_o), .trans_id_o(trans_id_o), .trans_we_o(trans_we_o),
    .trans_last_o(trans_last_o), .aw_sync_o(aw_sync_o), .ar_sync_o(ar_sync_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [5:0]  id;
    logic        last;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  beat_t exp_q[$];
  int n_tests = 0, n_fail = 0, n_beats = 0, n_aw_sync = 0, n_ar_sync = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every granted beat is popped and compared.
  always @(negedge clk_i) begin
    beat_t e;
    if (rst_ni) begin
      if (aw_sync_o) n_aw_sync++;
      if (ar_sync_o) n_ar_sync++;
      if (aw_sync_o || ar_sync_o) chk("sync_excl", 64'(aw_sync_o & ar_sync_o), 0);
      if (trans_valid_o) begin
        n_beats++;
        chk("beat_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_addr", per_add_o, e.addr);
          chk("beat_we_n", per_we_n_o, !e.we);
          chk("beat_be", per_be_o, e.be);
          chk("beat_id", trans_id_o, e.id);
          chk("beat_we", trans_we_o, e.we);
          chk("beat_last", trans_last_o, e.last);
          if (e.we) chk("beat_wdata", per_wdata_o, e.data);
        end
      end
    end
  end

  // Expected model: beat 0 keeps the raw address, later beats are word-aligned
  // steps of 4 that wrap inside the 4 KiB page.
  task automatic push_burst(input logic [31:0] addr, input int len, input int n,
                            input logic [5:0] id, input logic we,
                            input logic [31:0] dbase, input logic [3:0] strb);
    beat_t e;
    logic [11:0] lo;
    for (int k = 0; k < n; k++) begin
      lo     = 12'((addr & 32'h0000_0FFC) + 32'(4 * k));
      e.addr = (k == 0) ? addr : ((addr & 32'hFFFF_F000) | {20'd0, lo});
      e.we   = we;
      e.id   = id;
      e.last = (k == len);
      e.data = dbase + 32'(k);
      e.be   = we ? strb : 4'hF;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_hs(input bit is_w, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      ok = is_w ? (aw_valid_i && aw_ready_o) : (ar_valid_i && ar_ready_o);
    end
    chk({tag, "_hs"}, 64'(ok), 1);
    chk({tag, "_aw_sync"}, 64'(aw_sync_o), 64'(is_w));
    chk({tag, "_ar_sync"}, 64'(ar_sync_o), 64'(!is_w));
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && exp_q.size() > 0; i++) begin
      @(negedge clk_i); #1;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, b0;
    rst_ni = 1'b0;
    aw_valid_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_id_i = 0;
    w_valid_i = 0; w_data_i = 0; w_strb_i = 0;
    ar_valid_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_id_i = 0;
    per_gnt_i = 0;
    repeat (3) @(posedge clk_i); #1;

    // Reset values
    chk("rst_aw_ready", aw_ready_o, 0);
    chk("rst_ar_ready", ar_ready_o, 0);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_per_req", per_req_o, 0);
    chk("rst_we_n", per_we_n_o, 1);
    chk("rst_add", per_add_o, 0);
    chk("rst_wdata", per_wdata_o, 0);
    chk("rst_be", per_be_o, 0);
    chk("rst_trans", {trans_valid_o, trans_we_o, trans_last_o, trans_id_o}, 0);
    chk("rst_sync", {aw_sync_o, ar_sync_o}, 0);
    rst_ni = 1'b1;
    tick();

    // Single write, gnt tied high
    per_gnt_i = 1;
    a0 = n_aw_sync;
    aw_valid_i = 1; aw_addr_i = 32'h100; aw_len_i = 0; aw_id_i = 5;
    w_valid_i = 1; w_data_i = 32'hDEAD_BEEF; w_strb_i = 4'hF;
    push_burst(32'h100, 0, 1, 5, 1, 32'hDEAD_BEEF, 4'hF);
    wait_hs(1, "wr1");
    tick(); aw_valid_i = 0;
    @(negedge clk_i);
    chk("wr1_latency_req", per_req_o, 1);
    #1;
    tick(); w_valid_i = 0;
    wait_drain(5, "wr1");
    chk("wr1_sync_cnt", 64'(n_aw_sync - a0), 1);

    // Read burst of 4 on consecutive cycles
    ar_valid_i = 1; ar_addr_i = 32'h200; ar_len_i = 3; ar_id_i = 9;
    push_burst(32'h200, 3, 4, 9, 0, 0, 4'hF);
    wait_hs(0, "rd4");
    tick(); ar_valid_i = 0;
    repeat (4) @(negedge clk_i);
    #1;
    chk("rd4_consecutive", 64'(exp_q.size()), 0);
    @(negedge clk_i);
    chk("rd4_idle_req", per_req_o, 0);
    tick();

    // Tie from reset: read, write, read, write
    rst_ni = 0; tick(); rst_ni = 1; tick();
    aw_addr_i = 32'h300; aw_len_i = 0; aw_id_i = 1;
    ar_addr_i = 32'h400; ar_len_i = 0; ar_id_i = 2;
    w_valid_i = 1; w_data_i = 32'h55AA_0000; w_strb_i = 4'hC;
    for (int r = 0; r < 4; r++) begin
      bit rd;
      rd = (r % 2 == 0);
      aw_valid_i = 1; ar_valid_i = 1;
      if (rd) push_burst(32'h400, 0, 1, 2, 0, 0, 4'hF);
      else    push_burst(32'h300, 0, 1, 1, 1, 32'h55AA_0000, 4'hC);
      @(negedge clk_i);
      chk("tie_ar_ready", ar_ready_o, 64'(rd));
      chk("tie_aw_ready", aw_ready_o, 64'(!rd));
      tick();
      if (rd) ar_valid_i = 0; else aw_valid_i = 0;
      @(negedge clk_i); #1;
      chk("tie_beat_done", 64'(exp_q.size()), 0);
      tick();
    end
    aw_valid_i = 0; ar_valid_i = 0; w_valid_i = 0;
    tick();

    // 4 KiB wrap
    ar_valid_i = 1; ar_addr_i = 32'h1FFC; ar_len_i = 1; ar_id_i = 3;
    push_burst(32'h1FFC, 1, 2, 3, 0, 0, 4'hF);
    wait_hs(0, "wrap");
    tick(); ar_valid_i = 0;
    wait_drain(5, "wrap");
    tick();

    // Grant and W backpressure
    per_gnt_i = 0;
    b0 = n_beats;
    aw_valid_i = 1; aw_addr_i = 32'h500; aw_len_i = 3; aw_id_i = 7;
    w_valid_i = 1; w_data_i = 32'hB000; w_strb_i = 4'hF;
    push_burst(32'h500, 3, 4, 7, 1, 32'hB000, 4'hF);
    wait_hs(1, "bp");
    tick(); aw_valid_i = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("bp_req_held", per_req_o, 1);
      chk("bp_addr_stable", per_add_o, 32'h500);
      chk("bp_no_beat", trans_valid_o, 0);
    end
    tick(); per_gnt_i = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); #1;
      tick(); w_valid_i = 0;
      @(negedge clk_i);
      chk("bp_bubble_req", per_req_o, 0);
      tick();
      if (k < 3) begin w_valid_i = 1; w_data_i = 32'hB000 + 32'(k + 1); end
    end
    chk("bp_beat_cnt", 64'(n_beats - b0), 4);
    chk("bp_queue", 64'(exp_q.size()), 0);

    // Reset in the middle of an 8-beat write, after 3 beats
    b0 = n_beats;
    aw_valid_i = 1; aw_addr_i = 32'h600; aw_len_i = 7; aw_id_i = 3;
    w_valid_i = 1; w_data_i = 32'hA000; w_strb_i = 4'hF;
    push_burst(32'h600, 7, 3, 3, 1, 32'hA000, 4'hF);
    wait_hs(1, "mid");
    tick(); aw_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); #1;
      if (k < 2) begin tick(); w_data_i = 32'hA000 + 32'(k + 1); end
    end
    rst_ni = 0; #1;
    chk("mid_rst_req", per_req_o, 0);
    chk("mid_rst_we_n", per_we_n_o, 1);
    chk("mid_rst_add", per_add_o, 0);
    chk("mid_rst_w_ready", w_ready_o, 0);
    chk("mid_rst_be_data", {per_be_o, per_wdata_o}, 0);
    chk("mid_rst_trans", {trans_valid_o, trans_last_o, trans_id_o}, 0);
    chk("mid_beat_cnt", 64'(n_beats - b0), 3);
    chk("mid_queue", 64'(exp_q.size()), 0);
    tick(); w_valid_i = 0; rst_ni = 1;
    tick();
    a0 = n_aw_sync;
    aw_valid_i = 1; aw_addr_i = 32'h700; aw_len_i = 0; aw_id_i = 4;
    w_valid_i = 1; w_data_i = 32'hC0DE; w_strb_i = 4'h3;
    push_burst(32'h700, 0, 1, 4, 1, 32'hC0DE, 4'h3);
    wait_hs(1, "post");
    tick(); aw_valid_i = 0;
    wait_drain(5, "post");
    w_valid_i = 0;
    chk("post_sync_cnt", 64'(n_aw_sync - a0), 1);
    tick(); tick();

    chk("final_queue", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi2per_req_sequencer.md
# axi2per_req_sequencer

Front-end request stage of the AXI-to-peripheral bridge. Accepts AXI4 AW/W and AR bursts, arbitrates between write and read, and splits each burst into single-word peripheral requests. Emits one-cycle `aw_sync_o`/`ar_sync_o` pulses on burst acceptance, which feed the bridge busy unit. Passes per-beat transaction info to the response stage, which produces the B/R responses and the matching `b_sync`/`r_sync` pulses.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, 32, AXI and peripheral address width.
- `DATA_WIDTH`, 32, AXI and peripheral data width; fixed at 32, no width conversion.
- `ID_WIDTH`, 6, AXI ID width.

Ports:
- `clk_i`  in  1  clock; one clock; reset is asynchronous and active-low.
- `rst_ni`  in  1  asynchronous active-low reset.
- `aw_valid_i`/`aw_ready_o`  in/out  1  AW handshake.
- `aw_addr_i`  in  AXI_ADDR_WIDTH  write burst start address.
- `aw_len_i`  in  8  beats minus 1.
- `aw_id_i`  in  ID_WIDTH  write ID.
- `w_valid_i`/`w_ready_o`  in/out  1  W handshake.
- `w_data_i`  in  DATA_WIDTH  write data.
- `w_strb_i`  in  4  byte strobes.
- `ar_valid_i`/`ar_ready_o`, `ar_addr_i`, `ar_len_i`, `ar_id_i`  read equivalents of the AW signals.
- `per_req_o`  out  1  peripheral request.
- `per_gnt_i`  in  1  peripheral grant.
- `per_add_o`  out  AXI_ADDR_WIDTH  word address.
- `per_we_n_o`  out  1  0 = write.
- `per_wdata_o`  out  32  write data.
- `per_be_o`  out  4  byte enables.
- `trans_valid_o`  out  1  beat accepted by peripheral.
- `trans_id_o`  out  ID_WIDTH  ID of the accepted beat.
- `trans_we_o`  out  1  1 = write beat.
- `trans_last_o`  out  1  final beat of the burst.
- `aw_sync_o`, `ar_sync_o`  out  1  one-cycle pulse per accepted burst.

## Operation
- FSM states: IDLE, WRITE, READ. Reset state is IDLE.
- Arbitration in IDLE:
  - A write candidate requires `aw_valid_i`. `w_valid_i` is not required.
  - A read candidate requires `ar_valid_i`.
  - If only one candidate is present, it is served.
  - If both are present, the direction opposite to `last_served` is served. `last_served` resets to WRITE, so read wins the first tie.
- IDLE outputs: `aw_ready_o` = 1 only when the write is selected; `ar_ready_o` = 1 only when the read is selected. Both are combinational from the valids and `last_served`.
- On the AX handshake:
  - Capture addr, len into `beat_cnt`, id, and direction.
  - Pulse the matching `*_sync_o` in the same cycle.
  - Update `last_served`.
  - Go to WRITE or READ.
- WRITE state:
  - `per_req_o` = `w_valid_i`; `w_ready_o` = `per_gnt_i & w_valid_i`.
  - `per_wdata_o`/`per_be_o` are driven straight from W. `per_we_n_o` = 0.
- READ state: `per_req_o` = 1; `per_we_n_o` = 0 is not driven, i.e. `per_we_n_o` = 1; `per_be_o` = 4'hF.
- Each granted beat (`per_req_o & per_gnt_i`):
  - `trans_valid_o` = 1 with the captured id, the direction, and `trans_last_o` = (`beat_cnt` == 0).
  - Address increments by 4 in bits [11:0] only. The 4 KiB wrap holds the upper bits; bits [1:0] are forced to 0 after the first beat.
  - `beat_cnt` decrements.
- After the last granted beat, the FSM returns to IDLE. A new AX can be accepted in the following cycle; there are no back-to-back AX acceptances in the same cycle.
- Only `aw_addr_i` bits [1:0] are honoured on beat 0, through the strobes. Only INCR bursts are supported; the burst type is ignored.
- Outside WRITE, `w_ready_o` is 0. A W beat arriving before its AW waits.
- Reset mid-burst: all state clears asynchronously and the FSM goes to IDLE. Remaining beats are dropped.

## Timing
- Reset values: all `*_ready_o`, `per_req_o`, `trans_*_o` and `*_sync_o` are 0. `per_we_n_o` is 1. Address, data and be are 0.
- AX handshake to first `per_req_o`: 1 cycle.
- Peak throughput: 1 beat per cycle while `per_gnt_i` is held high. A burst of N beats occupies N+1 cycles.
- `per_req_o` stays high with stable address until granted. Under W backpressure, `per_req_o` drops with `w_valid_i`.
- `*_sync_o` is exactly one cycle wide, one pulse per burst, and never asserted for both directions in the same cycle.

## Structure
- Shared package `axi2per_pkg`:
  - `seq_state_e`.
  - Direction enum.
  - Constant `AXI2PER_4K_MASK`.
  - `trans_info_t` struct (id, we, last), shared with the response stage.
- A single sub-module `axi2per_rr_arb2` (2-way arbiter holding the `last_served` flop) is natural. Everything else stays flat.

## Test plan
- Single write: AW addr 0x100, len 0, id 5, W data 0xDEADBEEF, strb F; gnt tied high. Expect one `aw_sync_o` pulse, `per_add_o` 0x100, `per_we_n_o` 0, and trans id 5 with last = 1.
- Read burst of 4: AR addr 0x200, len 3, gnt high. Expect addresses 0x200, 0x204, 0x208, 0x20C on consecutive cycles and `trans_last_o` only on the fourth beat.
- Simultaneous AW and AR from reset. Expect read first, then write; with both re-presented, they alternate.
- 4 KiB wrap: AR addr 0x1FFC, len 1. Expect the second address 0x1000.
- Backpressure: `per_gnt_i` low for 3 cycles, then W valid toggling. Expect address stable, no beat loss, and `trans_valid_o` count equal to len+1.
- Reset asserted mid 8-beat write after 3 beats. Expect immediate IDLE with all outputs at reset values; a new AW is then accepted normally.
